// File: rtl/switch_sequencer.sv
// switch_sequencer: steps through a table of (pulse width, dwell) entries,
// restarting the width decoder for each entry and enabling the PWM while it dwells.
// Ports:
//   clk, reset (async, active high), en (global freeze), en_1MHz (dwell tick)
//   wr_en/wr_addr/wr_w/wr_dwell : pattern table write port
//   last_idx, loop              : sequence length and wrap control
//   start, stop                 : one-cycle start / abort requests
//   dec_done                    : decoder finished with the current width
//   W, dec_reset                : width word and restart pulse to the decoder
//   pwm_en                      : PWM enable, high only while an entry dwells
//   busy, cur_idx, seq_done, err: status (err is a sticky decoder timeout)
module switch_sequencer #(
    parameter int DEPTH = 8,
    parameter int WW    = 13,
    parameter int DW    = 8,
    parameter int TMO   = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     en_1MHz,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WW-1:0]            wr_w,
    input  logic [DW-1:0]            wr_dwell,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     dec_done,
    output logic [WW-1:0]            W,
    output logic                     dec_reset,
    output logic                     pwm_en,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     seq_done,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DECODE,
        RUN,
        NEXT
    } state_t;

    state_t state_q, state_d;

    logic [WW-1:0] tab_w     [DEPTH];
    logic [DW-1:0] tab_dwell [DEPTH];

    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0] idx_d;
    logic [WW-1:0] w_d;
    logic          set_err;
    logic          clr_err;
    logic          done_d;

    // Table writes ignore en and the FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_w[i]     <= '0;
                tab_dwell[i] <= '0;
            end
        end else if (wr_en) begin
            tab_w[wr_addr]     <= wr_w;
            tab_dwell[wr_addr] <= wr_dwell;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = cur_idx;
        w_d     = W;
        dwell_d = dwell_q;
        tcnt_d  = tcnt_q;
        set_err = 1'b0;
        clr_err = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    idx_d   = '0;
                    clr_err = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                w_d     = tab_w[cur_idx];
                dwell_d = tab_dwell[cur_idx];
                tcnt_d  = '0;
                state_d = DECODE;
            end
            DECODE: begin
                if (dec_done) begin
                    state_d = RUN;
                end else if (tcnt_q == CW'(TMO - 1)) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            RUN: begin
                // A dwell of 0 behaves like 1: leave on the first tick.
                if (en_1MHz) begin
                    if (dwell_q <= DW'(1)) begin
                        state_d = NEXT;
                    end else begin
                        dwell_d = dwell_q - DW'(1);
                    end
                end
            end
            NEXT: begin
                // >= so that shrinking last_idx mid-run still ends cleanly.
                if (cur_idx >= last_idx) begin
                    if (loop) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    idx_d   = cur_idx + AW'(1);
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every other transition, including a timeout.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            set_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_idx  <= '0;
            W        <= '0;
            dwell_q  <= '0;
            tcnt_q   <= '0;
            pwm_en   <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            cur_idx  <= idx_d;
            W        <= w_d;
            dwell_q  <= dwell_d;
            tcnt_q   <= tcnt_d;
            // Registered from the next state so it tracks RUN exactly.
            pwm_en   <= (state_d == RUN);
            seq_done <= done_d;
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    assign dec_reset = (state_q == LOAD);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: self-checking bench for switch_sequencer.
// Models the decoder and tick source; checks entries played at transaction level.
module tb_switch_sequencer;

    localparam int DEPTH = 8;
    localparam int WW    = 13;
    localparam int DW    = 8;
    localparam int TMO   = 60;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          en_1MHz = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_w;
    logic [DW-1:0] wr_dwell;
    logic [AW-1:0] last_idx;
    logic          loop;
    logic          start;
    logic          stop;
    logic          dec_done = 1'b0;
    logic [WW-1:0] W;
    logic          dec_reset;
    logic          pwm_en;
    logic          busy;
    logic [AW-1:0] cur_idx;
    logic          seq_done;
    logic          err;

    switch_sequencer #(
        .DEPTH(DEPTH), .WW(WW), .DW(DW), .TMO(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .en_1MHz  (en_1MHz),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_w     (wr_w),
        .wr_dwell (wr_dwell),
        .last_idx (last_idx),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .dec_done (dec_done),
        .W        (W),
        .dec_reset(dec_reset),
        .pwm_en   (pwm_en),
        .busy     (busy),
        .cur_idx  (cur_idx),
        .seq_done (seq_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Decoder model: dec_done rises dec_lat cycles after dec_reset.
    int dec_lat  = 4;
    bit dec_hold = 1'b0;
    int dcnt     = 0;
    always begin
        @(posedge clk);
        #1;
        if (dec_hold) begin
            dec_done = 1'b0;
            dcnt     = 0;
        end else if (dec_reset === 1'b1) begin
            dcnt     = dec_lat;
            dec_done = 1'b0;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) dec_done = 1'b1;
        end
    end

    // Tick source: one-cycle pulse every tick_per cycles.
    int tick_per = 3;
    int tk       = 0;
    always begin
        @(posedge clk);
        #1;
        if (tk <= 0) begin
            en_1MHz = 1'b1;
            tk      = tick_per - 1;
        end else begin
            en_1MHz = 1'b0;
            tk--;
        end
    end

    // Monitor: one record per pwm_en high period (W seen, ticks counted).
    typedef struct {
        int w;
        int t;
    } rec_t;

    rec_t recs[$];
    int   cur_w  = 0;
    int   cur_t  = 0;
    int   gap    = 0;
    int   sd_cnt = 0;
    bit   prev_pwm = 1'b0;
    bit   drift    = 1'b0;
    bit   in_seq   = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (pwm_en === 1'b1) begin
            if (!prev_pwm) begin
                if (in_seq) chk("pwm_gap", 32'(gap >= 2), 32'd1);
                cur_w  = int'(W);
                cur_t  = 0;
                drift  = 1'b0;
                in_seq = 1'b1;
            end else if (int'(W) != cur_w) begin
                drift = 1'b1;
            end
            if (en === 1'b1 && en_1MHz === 1'b1) cur_t++;
        end else begin
            if (prev_pwm) begin
                recs.push_back('{cur_w, cur_t});
                chk("w_hold", 32'(drift), 32'd0);
                gap = 0;
            end
            gap++;
        end
        if (busy !== 1'b1) in_seq = 1'b0;
        if (seq_done === 1'b1) sd_cnt++;
        prev_pwm = (pwm_en === 1'b1);
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int w, input int d);
        wr_addr  = AW'(a);
        wr_w     = WW'(w);
        wr_dwell = DW'(d);
        wr_en    = 1'b1;
        step();
        wr_en    = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear;
        recs.delete();
        sd_cnt = 0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy === 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        step();
        step();
    endtask

    task automatic wait_pwm(input int max);
        int n = 0;
        while (pwm_en !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("pwm_timeout", 32'(pwm_en), 32'd1);
    endtask

    task automatic wait_recs(input int cnt, input int max);
        int n = 0;
        while (recs.size() < cnt && n < max) begin
            step();
            n++;
        end
        chk("rec_timeout", 32'(recs.size() >= cnt), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_W"}, 32'(W), 32'd0);
        chk({tag, "_dec_reset"}, 32'(dec_reset), 32'd0);
        chk({tag, "_pwm_en"}, 32'(pwm_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cur_idx"}, 32'(cur_idx), 32'd0);
        chk({tag, "_seq_done"}, 32'(seq_done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    typedef struct {
        int w;
        int d;
        int exp_w;
        int exp_t;
    } vec_t;

    vec_t vec[3];
    int   tw[DEPTH];
    int   td[DEPTH];

    initial begin
        vec[0] = '{100, 3, 100, 3};
        vec[1] = '{2000, 1, 2000, 1};
        vec[2] = '{8191, 2, 8191, 2};

        reset    = 1'b1;
        en       = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_w     = '0;
        wr_dwell = '0;
        last_idx = '0;
        loop     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        repeat (3) step();
        chk_reset_outs("rst");
        reset = 1'b0;
        step();

        // Basic three-entry sequence, with a start during RUN that must be ignored.
        for (int i = 0; i < 3; i++) wr(i, vec[i].w, vec[i].d);
        last_idx = 3'd2;
        loop     = 1'b0;
        dec_lat  = 4;
        tick_per = 4;
        clear();
        go();
        chk("load_dec_reset", 32'(dec_reset), 32'd1);
        wait_pwm(200);
        go();
        wait_idle(2000);
        chk("basic_recs", 32'(recs.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < recs.size()) begin
                chk("basic_w", 32'(recs[i].w), 32'(vec[i].exp_w));
                chk("basic_ticks", 32'(recs[i].t), 32'(vec[i].exp_t));
            end
        end
        chk("basic_seq_done", 32'(sd_cnt), 32'd1);
        chk("basic_w_final", 32'(W), 32'd8191);

        // Looping: wraps to entry 0 without seq_done, then abort in RUN.
        loop = 1'b1;
        clear();
        go();
        wait_recs(4, 3000);
        if (recs.size() >= 4) chk("loop_wrap_w", 32'(recs[3].w), 32'd100);
        chk("loop_no_done", 32'(sd_cnt), 32'd0);
        wait_pwm(200);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_pwm", 32'(pwm_en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        step();
        chk("stop_no_done", 32'(sd_cnt), 32'd0);

        // Rewriting the playing entry affects only the next pass.
        clear();
        go();
        wait_pwm(200);
        wr(0, 500, 3);
        wait_recs(4, 3000);
        if (recs.size() >= 4) begin
            chk("wr_run_cur", 32'(recs[0].w), 32'd100);
            chk("wr_run_next", 32'(recs[3].w), 32'd500);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(50);

        // Shrinking last_idx below cur_idx ends the sequence after the entry.
        loop     = 1'b0;
        last_idx = 3'd5;
        clear();
        go();
        wait_recs(2, 3000);
        wait_pwm(200);
        last_idx = 3'd0;
        wait_idle(2000);
        chk("shrink_recs", 32'(recs.size()), 32'd3);
        chk("shrink_done", 32'(sd_cnt), 32'd1);

        // Decoder timeout: IDLE reached TMO+1 cycles after LOAD, err sticky.
        dec_hold = 1'b1;
        last_idx = 3'd0;
        clear();
        go();
        chk("tmo_load", 32'(dec_reset), 32'd1);
        begin
            int n = 0;
            while (busy === 1'b1 && n < TMO + 20) begin
                step();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'(TMO + 1));
        end
        chk("tmo_err", 32'(err), 32'd1);
        repeat (5) step();
        chk("tmo_err_sticky", 32'(err), 32'd1);
        chk("tmo_no_pwm", 32'(recs.size()), 32'd0);
        dec_hold = 1'b0;
        go();
        chk("start_clr_err", 32'(err), 32'd0);
        wait_idle(2000);

        // en low in RUN freezes the dwell while ticks keep coming.
        wr(0, 321, 4);
        last_idx = 3'd0;
        tick_per = 3;
        clear();
        go();
        wait_pwm(200);
        begin
            int n = 0;
            while (cur_t < 1 && n < 50) begin
                step();
                n++;
            end
        end
        en = 1'b0;
        repeat (10) step();
        chk("en_hold_pwm", 32'(pwm_en), 32'd1);
        chk("en_hold_busy", 32'(busy), 32'd1);
        chk("en_hold_w", 32'(W), 32'd321);
        en = 1'b1;
        wait_idle(2000);
        chk("en_recs", 32'(recs.size()), 32'd1);
        if (recs.size() >= 1) chk("en_ticks", 32'(recs[0].t), 32'd4);

        // Randomized tables against the expected playback order.
        for (int r = 0; r < 6; r++) begin
            int li;
            for (int i = 0; i < DEPTH; i++) begin
                tw[i] = int'($urandom_range(0, 8191));
                td[i] = int'($urandom_range(0, 4));
                wr(i, tw[i], td[i]);
            end
            li       = int'($urandom_range(0, DEPTH - 1));
            last_idx = AW'(li);
            loop     = 1'b0;
            tick_per = int'($urandom_range(2, 6));
            dec_lat  = int'($urandom_range(1, 10));
            clear();
            go();
            wait_idle(4000);
            chk("rnd_recs", 32'(recs.size()), 32'(li + 1));
            for (int i = 0; i <= li; i++) begin
                if (i < recs.size()) begin
                    chk("rnd_w", 32'(recs[i].w), 32'(tw[i]));
                    chk("rnd_ticks", 32'(recs[i].t),
                        32'((td[i] == 0) ? 1 : td[i]));
                end
            end
            chk("rnd_done", 32'(sd_cnt), 32'd1);
        end

        // Asynchronous reset in RUN, then the table must read back as zero.
        wr(0, 77, 5);
        last_idx = 3'd0;
        clear();
        go();
        wait_pwm(200);
        reset = 1'b1;
        #1;
        chk_reset_outs("arst");
        step();
        reset = 1'b0;
        step();
        go();
        wait_pwm(200);
        chk("arst_table_w", 32'(W), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_sequencer.md
SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, number of pattern-table entries (power of two).
REQ-002 Parameter WW, default 13, pulse-width word width.
REQ-003 Parameter DW, default 8, dwell-count width, in en_1MHz ticks.
REQ-004 Parameter TMO, default 255, decoder timeout in clk cycles.
REQ-005 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  global enable; low freezes the FSM, counters and all outputs.
REQ-008 en_1MHz  in  1  single-clk tick from the 1 MHz enable generator.
REQ-009 wr_en  in  1  table write strobe.
REQ-010 wr_addr  in  log2(DEPTH)  table write index.
REQ-011 wr_w  in  WW  pulse width to store.
REQ-012 wr_dwell  in  DW  dwell to store.
REQ-013 last_idx  in  log2(DEPTH)  index of the final active entry.
REQ-014 loop  in  1  when high, the sequence wraps after last_idx.
REQ-015 start  in  1  single-cycle start request.
REQ-016 stop  in  1  single-cycle abort request.
REQ-017 dec_done  in  1  done flag from the width decoder.
REQ-018 W  out  WW  width word driven to the decoder.
REQ-019 dec_reset  out  1  one-cycle restart pulse to the decoder.
REQ-020 pwm_en  out  1  enable to the PWM generator.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 cur_idx  out  log2(DEPTH)  index of the entry currently being played.
REQ-023 seq_done  out  1  one-cycle pulse when a non-loop sequence completes.
REQ-024 err  out  1  sticky decoder-timeout flag.

Function
REQ-025 The table SHALL be DEPTH x (WW+DW) registers; a write on wr_en takes effect on the next edge in every state, including while the sequence is running.
REQ-026 The FSM SHALL have the states IDLE, LOAD, DECODE, RUN and NEXT.
REQ-027 IDLE: on start (and stop low), set cur_idx=0 and go to LOAD; start in any other state is ignored.
REQ-028 LOAD: W <= table[cur_idx].w; dwell counter <= table[cur_idx].dwell; dec_reset=1 for exactly this cycle; then go to DECODE.
REQ-029 DECODE: count clk cycles; on dec_done=1 go to RUN; if the count reaches TMO with dec_done still 0, set err=1 and go to IDLE.
REQ-030 RUN: pwm_en=1; on each en_1MHz tick decrement the dwell counter; when a tick arrives with the counter at 1, go to NEXT; an entry with dwell=0 leaves RUN on its first tick.
REQ-031 NEXT: pwm_en=0; if cur_idx==last_idx, then with loop=1 set cur_idx=0 and go to LOAD, and with loop=0 pulse seq_done and go to IDLE; otherwise cur_idx+1 and go to LOAD.
REQ-032 pwm_en SHALL be registered, high only in RUN, and low for at least 2 clk (NEXT and LOAD) between entries.
REQ-033 W SHALL hold its value outside LOAD; changes to table[cur_idx] during DECODE or RUN do not affect the entry currently playing.
REQ-034 stop in any state other than IDLE SHALL force IDLE on the next edge with pwm_en=0; no seq_done pulse is generated; stop has priority over start and over every other transition.
REQ-035 If last_idx changes mid-sequence, the new value is sampled in NEXT; if cur_idx>last_idx at that point, the sequence ends as if cur_idx==last_idx.
REQ-036 en=0 SHALL hold the state, the counters and pwm_en; en_1MHz ticks that arrive while en=0 are not counted.
REQ-037 err SHALL be cleared only by reset or by an accepted start.

Reset
REQ-038 While reset is high: state=IDLE; W=0; dec_reset=0; pwm_en=0; busy=0; cur_idx=0; seq_done=0; err=0; all table entries=0.
REQ-039 When reset is asserted mid-sequence, pwm_en SHALL fall asynchronously, with no clk edge required.

Verification
REQ-040 Write entries 0..2 with (w,dwell)=(100,3),(2000,1),(8191,2), set last_idx=2 and loop=0, pulse start, and return dec_done 4 clk after each dec_reset -> W steps 100, 2000, 8191; pwm_en stays high for 3, 1 and 2 ticks respectively; one seq_done pulse; busy then falls.
REQ-041 Same table with loop=1 -> after entry 2, cur_idx returns to 0 with W=100 and no seq_done pulse; stop in RUN -> pwm_en=0 and busy=0 on the next edge.
REQ-042 Hold dec_done=0 -> err=1 and IDLE reached TMO+1 cycles after LOAD; pwm_en never rises.
REQ-043 Write entry 0 with w=500 while RUN is playing entry 0 -> the current entry keeps its original W; the next loop iteration outputs W=500.
REQ-044 Drop en low for 10 cycles in RUN while ticks continue -> the dwell does not advance; playback resumes with the remaining count once en returns high.
REQ-045 Assert reset asynchronously in RUN -> pwm_en=0 immediately and all outputs at the values in REQ-038.
